// File: rtl/wb_host_master_if.sv
// Host-side byte streams plus the Wishbone master bus of wb_host_master.
interface wb_host_master_if;
  logic [7:0]  rx_dat;
  logic        rx_stb;
  logic [7:0]  tx_dat;
  logic        tx_stb;
  logic        tx_rdy;
  logic        busy;
  logic [15:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic        wb_ack_i;

  modport master (
    input  rx_dat, rx_stb, tx_rdy, wb_dat_i, wb_ack_i,
    output tx_dat, tx_stb, busy, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o
  );

  modport slave (
    output rx_dat, rx_stb, tx_rdy, wb_dat_i, wb_ack_i,
    input  tx_dat, tx_stb, busy, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o
  );
endinterface

// File: rtl/wb_host_master.sv
// Serial-command Wishbone master: 'W' AH AL D writes, 'R' AH AL reads, and
// one response byte ('.', read data, or '!' on timeout) is returned.
// Optional bus watchdog enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  wb_host_master_if.master bus
);

  localparam int unsigned ADR_W = 16;
  localparam int unsigned DAT_W = 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADRH = 3'd1;
  localparam logic [2:0] ADRL = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] BUS  = 3'd4;
  localparam logic [2:0] RESP = 3'd5;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] RSP_WR = 8'h2E;
  localparam logic [7:0] RSP_TO = 8'h21;

  // Reject watchdog limits outside the 16-bit counter range at elaboration.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("wb_host_master: TIMEOUT out of range 1..65535");
  end

  logic [2:0]       state_q,  state_n;
  logic             we_q,     we_n;
  logic [ADR_W-1:0] adr_q,    adr_n;
  logic [DAT_W-1:0] dat_q,    dat_n;
  logic [DAT_W-1:0] tx_dat_q, tx_dat_n;
  logic             tx_stb_q, tx_stb_n;
  logic             cyc_q,    cyc_n;
  logic             busy_q,   busy_n;
`ifdef WB_HOST_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_n;
`endif

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      tx_dat_q <= '0;
      tx_stb_q <= 1'b0;
      cyc_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef WB_HOST_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_n;
      we_q     <= we_n;
      adr_q    <= adr_n;
      dat_q    <= dat_n;
      tx_dat_q <= tx_dat_n;
      tx_stb_q <= tx_stb_n;
      cyc_q    <= cyc_n;
      busy_q   <= busy_n;
`ifdef WB_HOST_TIMEOUT_EN
      cnt_q    <= cnt_n;
`endif
    end
  end

  // Next-state and next-output decode for the command/bus/response sequence.
  always_comb begin
    state_n  = state_q;
    we_n     = we_q;
    adr_n    = adr_q;
    dat_n    = dat_q;
    tx_dat_n = tx_dat_q;
    tx_stb_n = tx_stb_q;
    cyc_n    = cyc_q;
`ifdef WB_HOST_TIMEOUT_EN
    cnt_n    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rx_stb && bus.rx_dat == CMD_WR) begin
          we_n    = 1'b1;
          state_n = ADRH;
        end else if (bus.rx_stb && bus.rx_dat == CMD_RD) begin
          we_n    = 1'b0;
          state_n = ADRH;
        end
      end
      ADRH: begin
        if (bus.rx_stb) begin
          adr_n[15:8] = bus.rx_dat;
          state_n     = ADRL;
        end
      end
      ADRL: begin
        if (bus.rx_stb) begin
          adr_n[7:0] = bus.rx_dat;
          state_n    = we_q ? DATA : BUS;
`ifdef WB_HOST_TIMEOUT_EN
          cnt_n      = '0;
`endif
        end
      end
      DATA: begin
        if (bus.rx_stb) begin
          dat_n   = bus.rx_dat;
          state_n = BUS;
`ifdef WB_HOST_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      BUS: begin
        // Strobe opens one edge after entry; an ack beats a same-cycle timeout.
        if (!cyc_q) begin
          cyc_n = 1'b1;
        end else if (bus.wb_ack_i) begin
          cyc_n    = 1'b0;
          tx_dat_n = we_q ? RSP_WR : bus.wb_dat_i;
          tx_stb_n = 1'b1;
          state_n  = RESP;
        end
`ifdef WB_HOST_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          cyc_n    = 1'b0;
          tx_dat_n = RSP_TO;
          tx_stb_n = 1'b1;
          state_n  = RESP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (bus.tx_rdy) begin
          tx_stb_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.tx_dat   = tx_dat_q;
  assign bus.tx_stb   = tx_stb_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 Parameter TIMEOUT, default 255: bus watchdog limit in clk cycles, range 1..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx_dat  input  8  command byte from serial receiver.
REQ-005 rx_stb  input  1  single-cycle strobe, rx_dat valid.
REQ-006 tx_dat  output  8  response byte to serial transmitter.
REQ-007 tx_stb  output  1  response valid; held until accepted.
REQ-008 tx_rdy  input  1  transmitter can accept; a transfer occurs on an edge where tx_stb and tx_rdy are both high.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 wb_adr_o  output  16  bus address.
REQ-011 wb_dat_o  output  8  write data.
REQ-012 wb_dat_i  input  8  read data, sampled with wb_ack_i.
REQ-013 wb_cyc_o  output  1  bus cycle.
REQ-014 wb_stb_o  output  1  bus strobe; always equal to wb_cyc_o.
REQ-015 wb_we_o  output  1  1 = write, 0 = read.
REQ-016 wb_ack_i  input  1  slave acknowledge.

Function
REQ-017 FSM states: IDLE, ADRH, ADRL, DATA, BUS, RESP.
REQ-018 IDLE: rx_stb with 0x57 ('W') -> ADRH, we latched 1; with 0x52 ('R') -> ADRH, we latched 0; any other byte is ignored and the FSM stays in IDLE.
REQ-019 ADRH: rx_stb loads wb_adr_o[15:8] -> ADRL.
REQ-020 ADRL: rx_stb loads wb_adr_o[7:0] -> DATA if write, otherwise -> BUS.
REQ-021 DATA: rx_stb loads wb_dat_o -> BUS.
REQ-022 wb_cyc_o/wb_stb_o rise on the first clk edge after entering BUS; wb_adr_o, wb_dat_o and wb_we_o stay stable while wb_cyc_o is high.
REQ-023 BUS: wb_ack_i high -> drop wb_cyc_o/wb_stb_o on the same edge, go to RESP; on a read, latch wb_dat_i into tx_dat.
REQ-024 Response byte: read = latched wb_dat_i; write = 0x2E ('.'); timeout = 0x21 ('!').
REQ-025 RESP: tx_stb high; on an edge with tx_rdy high, clear tx_stb and go to IDLE.
REQ-026 rx_stb received in BUS or RESP is dropped; no state or register change.
REQ-027 wb_ack_i outside BUS is ignored.
REQ-028 Minimum cycle: wb_cyc_o is high exactly 1 clk when wb_ack_i is high on its first cycle.
REQ-029 Address and data registers keep their values after a command completes; they are not cleared.

Reset
REQ-030 While rst is high: FSM = IDLE, and wb_cyc_o, wb_stb_o, wb_we_o, tx_stb and busy are 0; wb_adr_o = 0x0000, wb_dat_o = 0x00, tx_dat = 0x00.
REQ-031 Assertion of rst during BUS drops wb_cyc_o/wb_stb_o immediately, without waiting for a clock edge; no response byte is sent.
REQ-032 The first command is accepted on the first rx_stb after rst deasserts.

Configuration
REQ-033 Macro WB_HOST_TIMEOUT_EN selects the bus watchdog.
REQ-034 Defined: a 16-bit counter clears on entry to BUS and counts each cycle that wb_cyc_o is high with no ack.
REQ-035 Defined: when the count reaches TIMEOUT, the block drops wb_cyc_o/wb_stb_o, loads tx_dat = 0x21 and goes to RESP.
REQ-036 Defined: an ack arriving in the same cycle as the timeout wins, and the normal response is sent.
REQ-037 Not defined: the counter is absent, and BUS waits for wb_ack_i indefinitely.

Verification
REQ-038 Write: rx bytes 0x57, 0x12, 0x34, 0xA5; slave acks after 2 cycles -> one cycle with adr=0x1234, dat_o=0xA5, we=1; then tx_dat=0x2E.
REQ-039 Read: rx bytes 0x52, 0xFF, 0xFC; slave returns 0x3C with ack after 0 wait states -> cyc high 1 clk, we=0; then tx_dat=0x3C.
REQ-040 Garbage then command: rx 0x00, 0x41, then the REQ-039 sequence -> the first two bytes produce no bus cycle; the read completes normally.
REQ-041 Backpressure: tx_rdy held low 10 cycles in RESP; rx 0x57 injected meanwhile -> tx_stb stays high with a stable byte, the injected byte is dropped, and busy stays 1 until the transfer.
REQ-042 Timeout (macro defined, TIMEOUT=8): read with no ack -> cyc drops 8 cycles after rising, tx_dat=0x21; a second command then works normally.
REQ-043 Reset mid-cycle: assert rst while wb_cyc_o is high -> cyc, stb and busy go to 0 asynchronously; after release a write completes normally.
